// File: rtl/if_fetch_queue_if.sv
// Fetch queue bus: PC-stage capture, flush and the decode-side valid/ready head port.
// The master side is the PC stage / decode pair, the slave side is the queue.
interface if_fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              ce;
  logic [ADDR_W-1:0] pc_i;
  logic [INST_W-1:0] inst_i;
  logic              stall_o;
  logic              flush_i;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output ce, pc_i, inst_i, flush_i, id_ready,
    input  stall_o, id_valid, id_pc, id_inst, count_o
  );

  modport slave (
    input  ce, pc_i, inst_i, flush_i, id_ready,
    output stall_o, id_valid, id_pc, id_inst, count_o
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch-side FIFO between the PC stage and decode; stall_o holds the PC while full.
// Optional IFQ_BYPASS_EN: an empty queue forwards the incoming pair combinationally.
module if_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  if_fetch_queue_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full, w_empty, w_push, w_pop, w_byp;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef IFQ_BYPASS_EN
  assign w_byp = w_empty & bus.ce & ~bus.flush_i;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed pair that decode takes right away never occupies an entry.
  assign w_pop  = ~w_empty & bus.id_ready & ~bus.flush_i;
  assign w_push = bus.ce & ~w_full & ~bus.flush_i & ~(w_byp & bus.id_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= bus.pc_i;
      r_inst_mem[r_wr_ptr] <= bus.inst_i;
    end
  end

  // Empty queue reads as a NOP at address 0 unless the bypass is forwarding.
  always_comb begin
    bus.id_valid = 1'b0;
    bus.id_pc    = '0;
    bus.id_inst  = '0;
    if (!w_empty) begin
      bus.id_valid = 1'b1;
      bus.id_pc    = r_pc_mem[r_rd_ptr];
      bus.id_inst  = r_inst_mem[r_rd_ptr];
    end else if (w_byp) begin
      bus.id_valid = 1'b1;
      bus.id_pc    = bus.pc_i;
      bus.id_inst  = bus.inst_i;
    end
  end

  assign bus.stall_o = w_full;
  assign bus.count_o = r_count;
endmodule
